change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream stage of the 10 TK vending FSM.
- Consumes the FSM's per-cycle `purchase` and `cash_return` outputs and converts each vend/refund event into timed actuator drive:
  - a product-motor pulse;
  - N coin-ejector pulses of 5 TK each, where N = `cash_return` (0..3).
- Buffers one extra event while busy and flags any loss.

Parameters:
- MOTOR_CYC, 8: cycles `motor_on` is held high per product vend (>=1).
- PULSE_W, 2: cycles `coin_eject` is high per 5 TK coin (>=1).
- GAP_W, 2: low cycles after each coin pulse (>=1).
- CNT_W, 8: width of statistics counters (optional feature only).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- purchase  input  1  vend request from vending FSM, sampled every edge.
- cash_return  input  2  change request in 5 TK units (00=none, 01=5, 10=10, 11=15 TK).
- motor_on  output  1  product motor drive, registered.
- coin_eject  output  1  5 TK coin ejector drive, registered.
- busy  output  1  high when an event is active or pending.
- overflow  output  1  sticky: an event was dropped.

Behaviour:
- Reset (`rst`=1 at edge):
  - state=IDLE; active and pending registers cleared.
  - `motor_on`, `coin_eject`, `busy`, `overflow` all 0.
  - Reset has priority over every other action; mid-operation it aborts immediately and discards pending.
- Event definition:
  - An event exists in any cycle where `purchase`=1 or `cash_return`!=0.
  - Payload is {prod=`purchase`, coins=`cash_return`}.
  - Each cycle is an independent event; there is no de-duplication.
- FSM states:
  - IDLE.
  - MOTOR: `motor_on`=1 for MOTOR_CYC cycles.
  - EJECT: `coin_eject`=1 for PULSE_W cycles.
  - GAP: outputs low for GAP_W cycles.
- Sequencing order: product first, then coins.
  - Load: prod=1 goes to MOTOR; prod=0 goes to EJECT.
  - MOTOR end: coins>0 goes to EJECT, else completion.
  - EJECT end: decrement coins, go to GAP.
  - GAP end: coins>0 goes to EJECT, else completion.
  - A gap always follows the last coin.
- Latency: an event sampled at edge N drives its first output (`motor_on` or `coin_eject`) high from edge N+1.
- Completion cycle (last cycle of the sequence):
  - If pending is valid, load pending directly into active; the next state begins with no IDLE bubble. An event arriving in the same cycle is stored into the freed pending slot.
  - If pending is empty and an event arrives, load it directly as active.
  - Otherwise go to IDLE.
- Busy handling:
  - An event arriving when state!=IDLE and not in the completion cycle is stored in pending if pending is empty.
  - If pending is full, the event is dropped and `overflow` is set to 1 until `rst`.
- `busy` = (state!=IDLE) or pending valid; it is registered with the state.
- `motor_on` and `coin_eject` are never high in the same cycle.
- Widths: coin count is 2 bits, decremented only in EJECT, never wraps below 0.

Optional Feature:
- Macro: `CHANGE_DISPENSER_STATS_EN`.
- When defined, two extra outputs are added:
  - `vend_count` [CNT_W-1:0]: increments on each entry to MOTOR.
  - `coin_count` [CNT_W-1:0]: increments on each entry to EJECT.
  - Both saturate at all-ones and clear on `rst`.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Vend + 10 TK change: event `purchase`=1, `cash_return`=10 at edge 0. Required:
  - `motor_on` high cycles 1-8;
  - `coin_eject` high cycles 9-10 and 13-14;
  - `busy` low from cycle 17; `overflow`=0.
- Refund only: `purchase`=0, `cash_return`=01 at edge 0. Required: `coin_eject` high cycles 1-2, `motor_on` never high, `busy` low from cycle 5.
- Pending chain: event A {1,00} at edge 0, event B {0,11} at edge 3. Required:
  - `motor_on` cycles 1-8;
  - `coin_eject` cycles 9-10, 13-14, 17-18;
  - `busy` low at cycle 21; `overflow`=0.
- Overflow: events {1,00} at edges 0, 1, 2. Required:
  - `overflow`=1 from cycle 3 and stays set;
  - `motor_on` high for exactly 16 cycles total (1-16).
- Reset mid-operation: event {1,11} at edge 0, `rst`=1 at edge 5. Required:
  - from cycle 6, all outputs 0 and state IDLE;
  - a new {0,01} event at edge 8 gives `coin_eject` high cycles 9-10.
- Stats (`CHANGE_DISPENSER_STATS_EN`): run the first and third scenarios back to back without reset. Required: `vend_count`=2, `coin_count`=5.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Handshake bundle between the vending FSM and the change dispenser.
// Statistics counters exist only when CHANGE_DISPENSER_STATS_EN is defined.
interface change_dispenser_if
`ifdef CHANGE_DISPENSER_STATS_EN
    #(parameter int unsigned CNT_W = 8)
`endif
    ;
    logic       purchase;
    logic [1:0] cash_return;
    logic       motor_on;
    logic       coin_eject;
    logic       busy;
    logic       overflow;
`ifdef CHANGE_DISPENSER_STATS_EN
    logic [CNT_W-1:0] vend_count;
    logic [CNT_W-1:0] coin_count;
`endif

    modport master (
        output purchase, cash_return,
`ifdef CHANGE_DISPENSER_STATS_EN
        input  vend_count, coin_count,
`endif
        input  motor_on, coin_eject, busy, overflow
    );

    modport slave (
        input  purchase, cash_return,
`ifdef CHANGE_DISPENSER_STATS_EN
        output vend_count, coin_count,
`endif
        output motor_on, coin_eject, busy, overflow
    );
endinterface

// File: rtl/change_dispenser.sv
// Turns vend/refund events into timed motor and coin-ejector pulses, with a one-deep
// pending slot; optional vend/coin counters under CHANGE_DISPENSER_STATS_EN.
module change_dispenser #(
    parameter int unsigned MOTOR_CYC = 8,
    parameter int unsigned PULSE_W   = 2,
    parameter int unsigned GAP_W     = 2
`ifdef CHANGE_DISPENSER_STATS_EN
    ,
    parameter int unsigned CNT_W     = 8
`endif
) (
    input logic             clk,
    input logic             rst,
    change_dispenser_if.slave bus
);
    localparam int unsigned MaxPw  = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int unsigned MaxCyc = (MOTOR_CYC > MaxPw) ? MOTOR_CYC : MaxPw;
    localparam int unsigned TmrW   = $clog2(MaxCyc + 1);

    typedef enum logic [1:0] {StIdle, StMotor, StEject, StGap} state_e;

    state_e            state_q, state_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [1:0]        coins_q, coins_d;
    logic              pend_vld_q, pend_vld_d;
    logic              pend_prod_q, pend_prod_d;
    logic [1:0]        pend_coins_q, pend_coins_d;
    logic              ovf_q, ovf_d;
    logic              motor_q, eject_q, busy_q, ovf_out_q;
    logic              motor_d, eject_d, busy_d;
    logic              ev, last, done, load, load_prod;
    logic [1:0]        load_coins;
    logic              enter_motor, enter_eject;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            tmr_q        <= '0;
            coins_q      <= '0;
            pend_vld_q   <= 1'b0;
            pend_prod_q  <= 1'b0;
            pend_coins_q <= '0;
            ovf_q        <= 1'b0;
            motor_q      <= 1'b0;
            eject_q      <= 1'b0;
            busy_q       <= 1'b0;
            ovf_out_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            coins_q      <= coins_d;
            pend_vld_q   <= pend_vld_d;
            pend_prod_q  <= pend_prod_d;
            pend_coins_q <= pend_coins_d;
            ovf_q        <= ovf_d;
            motor_q      <= motor_d;
            eject_q      <= eject_d;
            busy_q       <= busy_d;
            ovf_out_q    <= ovf_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        coins_d      = coins_q;
        pend_vld_d   = pend_vld_q;
        pend_prod_d  = pend_prod_q;
        pend_coins_d = pend_coins_q;
        ovf_d        = ovf_q;
        load         = 1'b0;
        load_prod    = 1'b0;
        load_coins   = 2'b00;
        enter_motor  = 1'b0;
        enter_eject  = 1'b0;
        ev   = bus.purchase || (bus.cash_return != 2'b00);
        last = (tmr_q == '0);
        // Completion: last cycle of MOTOR or GAP with no coins left to eject.
        done = last && (coins_q == 2'b00) && ((state_q == StMotor) || (state_q == StGap));

        if ((state_q == StIdle) || done) begin
            if (pend_vld_q) begin
                load         = 1'b1;
                load_prod    = pend_prod_q;
                load_coins   = pend_coins_q;
                pend_vld_d   = ev;
                pend_prod_d  = bus.purchase;
                pend_coins_d = bus.cash_return;
            end else if (ev) begin
                load       = 1'b1;
                load_prod  = bus.purchase;
                load_coins = bus.cash_return;
            end else begin
                state_d = StIdle;
            end
        end else begin
            if (ev) begin
                if (!pend_vld_q) begin
                    pend_vld_d   = 1'b1;
                    pend_prod_d  = bus.purchase;
                    pend_coins_d = bus.cash_return;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            unique case (state_q)
                StMotor, StGap: begin
                    if (last) begin
                        state_d     = StEject;
                        tmr_d       = TmrW'(PULSE_W - 1);
                        enter_eject = 1'b1;
                    end else begin
                        tmr_d = tmr_q - TmrW'(1);
                    end
                end
                StEject: begin
                    if (last) begin
                        state_d = StGap;
                        tmr_d   = TmrW'(GAP_W - 1);
                        coins_d = coins_q - 2'd1;
                    end else begin
                        tmr_d = tmr_q - TmrW'(1);
                    end
                end
                default: ;
            endcase
        end

        if (load) begin
            coins_d = load_coins;
            if (load_prod) begin
                state_d     = StMotor;
                tmr_d       = TmrW'(MOTOR_CYC - 1);
                enter_motor = 1'b1;
            end else begin
                state_d     = StEject;
                tmr_d       = TmrW'(PULSE_W - 1);
                enter_eject = 1'b1;
            end
        end
    end

    // Outputs are registered one stage after the state they reflect.
    always_comb begin
        motor_d = (state_q == StMotor);
        eject_d = (state_q == StEject);
        busy_d  = (state_q != StIdle) || pend_vld_q;
    end

    assign bus.motor_on   = motor_q;
    assign bus.coin_eject = eject_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = ovf_out_q;

`ifdef CHANGE_DISPENSER_STATS_EN
    logic [CNT_W-1:0] vend_q, coin_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vend_q <= '0;
            coin_q <= '0;
        end else begin
            if (enter_motor && (vend_q != '1)) vend_q <= vend_q + CNT_W'(1);
            if (enter_eject && (coin_q != '1)) coin_q <= coin_q + CNT_W'(1);
        end
    end

    assign bus.vend_count = vend_q;
    assign bus.coin_count = coin_q;
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench: per-scenario output traces over 32 cycles compared against
// hand-computed bit masks (bit k = cycle k after the event edge 0).
module tb_change_dispenser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mot_tr, ej_tr, busy_tr, ovf_tr;

    change_dispenser_if bus();

    change_dispenser #(
        .MOTOR_CYC(8),
        .PULSE_W  (2),
        .GAP_W    (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] prod;
        logic [63:0] cash;
        int          rst_at;
        logic [31:0] mot;
        logic [31:0] ej;
        logic [31:0] bsy;
        logic [31:0] ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.purchase = 1'b0;
        bus.cash_return = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Drives inputs for edges 0..31 and records outputs #1 after each edge.
    task automatic capture(input logic [31:0] prod, input logic [63:0] cash, input int rst_at);
        mot_tr = '0;
        ej_tr = '0;
        busy_tr = '0;
        ovf_tr = '0;
        for (int k = 0; k < 32; k++) begin
            bus.purchase    = prod[k];
            bus.cash_return = cash[2*k +: 2];
            rst             = (k == rst_at);
            @(posedge clk);
            #1;
            mot_tr[k]  = bus.motor_on;
            ej_tr[k]   = bus.coin_eject;
            busy_tr[k] = bus.busy;
            ovf_tr[k]  = bus.overflow;
            if (bus.motor_on && bus.coin_eject) begin
                checks++;
                errors++;
                $display("FAIL exclusive cycle %0d got motor=1 eject=1 want not both", k);
            end
        end
        rst = 1'b0;
        bus.purchase = 1'b0;
        bus.cash_return = 2'b00;
    endtask

    initial begin
        vecs[0] = '{"vend_10tk", 32'h1, 64'h2, -1,
                    32'h0000_01FE, 32'h0000_6600, 32'h0001_FFFE, 32'h0};
        vecs[1] = '{"refund_5tk", 32'h0, 64'h1, -1,
                    32'h0, 32'h0000_0006, 32'h0000_001E, 32'h0};
        vecs[2] = '{"pending_chain", 32'h1, 64'hC0, -1,
                    32'h0000_01FE, 32'h0006_6600, 32'h001F_FFFE, 32'h0};
        vecs[3] = '{"overflow", 32'h7, 64'h0, -1,
                    32'h0001_FFFE, 32'h0, 32'h0001_FFFE, 32'hFFFF_FFF8};
        vecs[4] = '{"reset_mid", 32'h1, 64'h1_0003, 5,
                    32'h0000_001E, 32'h0000_0600, 32'h0000_1E1E, 32'h0};
        vecs[5] = '{"refill_on_done", 32'h9, 64'h1_0000, -1,
                    32'h0001_FFFE, 32'h0006_0000, 32'h001F_FFFE, 32'h0};
        vecs[6] = '{"direct_on_done", 32'h10, 64'h1, -1,
                    32'h0000_1FE0, 32'h0000_0006, 32'h0000_1FFE, 32'h0};
        vecs[7] = '{"refund_15tk", 32'h0, 64'h3, -1,
                    32'h0, 32'h0000_0666, 32'h0000_1FFE, 32'h0};

        bus.purchase = 1'b0;
        bus.cash_return = 2'b00;
        reset_dut();
        check("reset_outputs",
              {28'h0, bus.motor_on, bus.coin_eject, bus.busy, bus.overflow}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            reset_dut();
            capture(vecs[i].prod, vecs[i].cash, vecs[i].rst_at);
            check({vecs[i].name, "_motor"}, mot_tr, vecs[i].mot);
            check({vecs[i].name, "_eject"}, ej_tr, vecs[i].ej);
            check({vecs[i].name, "_busy"}, busy_tr, vecs[i].bsy);
            check({vecs[i].name, "_overflow"}, ovf_tr, vecs[i].ovf);
        end

        // Overflow stays sticky across idle time until reset clears it.
        reset_dut();
        capture(32'h7, 64'h0, -1);
        repeat (5) @(posedge clk);
        #1;
        check("overflow_sticky", {31'h0, bus.overflow}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("overflow_cleared", {31'h0, bus.overflow}, 32'h0);

`ifdef CHANGE_DISPENSER_STATS_EN
        reset_dut();
        capture(vecs[0].prod, vecs[0].cash, -1);
        capture(vecs[2].prod, vecs[2].cash, -1);
        check("vend_count", 32'(bus.vend_count), 32'd2);
        check("coin_count", 32'(bus.coin_count), 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
